// File: rtl/core_csr_unit_if.sv
// core_csr_unit_if: CSR request/response bus between execute stage and CSR unit
interface core_csr_unit_if #(
  parameter int XLEN = 32
);
  logic            csr_req_i;
  logic [1:0]      csr_op_i;
  logic [11:0]     csr_addr_i;
  logic [XLEN-1:0] csr_wdata_i;
  logic            csr_ack_o;
  logic [XLEN-1:0] csr_rdata_o;
  logic            csr_illegal_o;
  modport master (
    output csr_req_i, csr_op_i, csr_addr_i, csr_wdata_i,
    input  csr_ack_o, csr_rdata_o, csr_illegal_o
  );
  modport slave (
    input  csr_req_i, csr_op_i, csr_addr_i, csr_wdata_i,
    output csr_ack_o, csr_rdata_o, csr_illegal_o
  );
endinterface

// File: rtl/core_csr_unit.sv
// core_csr_unit: scratch CSR bank plus cycle/time/instret counters with atomic RW/RS/RC access
module core_csr_unit #(
  parameter int XLEN      = 32,
  parameter int CSR_DEPTH = 8,
  parameter int CNT_WIDTH = 64,
  parameter int TIME_DIV  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic instret_i,
  core_csr_unit_if.slave bus
);
  localparam int AW = CSR_DEPTH > 1 ? $clog2(CSR_DEPTH) : 1;
  localparam int PW = TIME_DIV > 1 ? $clog2(TIME_DIV) : 1;
  logic [XLEN-1:0]      scr_q [CSR_DEPTH];
  logic [XLEN-1:0]      scr_d [CSR_DEPTH];
  logic [CNT_WIDTH-1:0] cyc_q, cyc_d, tim_q, tim_d, ins_q, ins_d;
  logic [PW-1:0]        pre_q, pre_d;
  logic                 ack_q, ack_d, ill_q, ill_d;
  logic [XLEN-1:0]      rd_q, rd_d;
  logic [11:0]          a;
  logic                 tick, is_scr, is_cnt, wr_intent, illegal;
  logic [CNT_WIDTH-1:0] cnt_sel;
  logic [2*XLEN-1:0]    cnt_x;
  logic [XLEN-1:0]      old, wval;
  assign a         = bus.csr_addr_i;
  assign tick      = pre_q == PW'(TIME_DIV - 1);
  assign is_scr    = a[11:6] == 6'h1F && 32'(a[5:0]) < CSR_DEPTH;
  assign is_cnt    = a[11:8] == 4'hC && a[6:2] == 5'd0 && a[1:0] != 2'd3;
  assign cnt_sel   = a[1:0] == 2'd0 ? cyc_q : a[1:0] == 2'd1 ? tim_q : ins_q;
  assign cnt_x     = (2*XLEN)'(cnt_sel);
  assign old       = is_cnt ? (a[7] ? cnt_x[2*XLEN-1:XLEN] : cnt_x[XLEN-1:0]) : scr_q[a[AW-1:0]];
  assign wr_intent = bus.csr_op_i == 2'b01 || (bus.csr_op_i[1] && bus.csr_wdata_i != '0);
  assign illegal   = !(is_scr || is_cnt) || (is_cnt && wr_intent);
  assign wval      = bus.csr_op_i == 2'b01 ? bus.csr_wdata_i :
                     bus.csr_op_i == 2'b10 ? old | bus.csr_wdata_i : old & ~bus.csr_wdata_i;
  // counters advance freely; prescaler wraps at TIME_DIV-1 and ticks time
  always_comb begin
    cyc_d = cyc_q + CNT_WIDTH'(1);
    ins_d = ins_q + CNT_WIDTH'(instret_i);
    tim_d = tim_q + CNT_WIDTH'(tick);
    pre_d = tick ? '0 : pre_q + PW'(1);
  end
  // request decode: scratch update and next registered response
  always_comb begin
    scr_d = scr_q;
    if (bus.csr_req_i && is_scr && wr_intent) scr_d[a[AW-1:0]] = wval;
    ack_d = bus.csr_req_i;
    ill_d = bus.csr_req_i && illegal;
    rd_d  = bus.csr_req_i && !illegal ? old : '0;
  end
  // state register; reset clears everything and drops any request in that cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scr_q <= '{default: '0};
      cyc_q <= '0;
      tim_q <= '0;
      ins_q <= '0;
      pre_q <= '0;
      ack_q <= 1'b0;
      ill_q <= 1'b0;
      rd_q  <= '0;
    end else begin
      scr_q <= scr_d;
      cyc_q <= cyc_d;
      tim_q <= tim_d;
      ins_q <= ins_d;
      pre_q <= pre_d;
      ack_q <= ack_d;
      ill_q <= ill_d;
      rd_q  <= rd_d;
    end
  end
  assign bus.csr_ack_o     = ack_q;
  assign bus.csr_illegal_o = ill_q;
  assign bus.csr_rdata_o   = rd_q;
endmodule

// File: tb/tb_core_csr_unit.sv
// tb_core_csr_unit: directed stimulus with a behavioural model checked every cycle
module tb_core_csr_unit;
  localparam int DEP = 8;
  localparam int TD  = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic instret = 1'b0;
  logic instret2 = 1'b0;
  int checks = 0;
  int failures = 0;
  bit armed = 1'b0;
  core_csr_unit_if #(.XLEN(32)) b1 ();
  core_csr_unit_if #(.XLEN(8))  b2 ();
  core_csr_unit #(.XLEN(32), .CSR_DEPTH(DEP), .CNT_WIDTH(64), .TIME_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n), .instret_i(instret), .bus(b1));
  core_csr_unit #(.XLEN(8), .CSR_DEPTH(1), .CNT_WIDTH(12), .TIME_DIV(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .instret_i(instret2), .bus(b2));
  always #5 clk = ~clk;
  logic [63:0] cyc_m, inst_m;
  logic [31:0] scr_m [DEP];
  logic        e_ack, e_ill;
  logic [31:0] e_rd;
  logic [11:0] c2;
  logic        e2_ack, e2_ill;
  logic [7:0]  e2_rd;
  logic        s2_req = 1'b0;
  logic [11:0] s2_addr = 12'h0;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask
  task automatic step(input bit rn, input bit rq, input logic [1:0] op,
                      input logic [11:0] ad, input logic [31:0] wd, input bit ir);
    logic [63:0] tm;
    logic [31:0] v;
    logic [7:0]  v2;
    bit hit, hit2, wi, ill;
    int idx;
    @(negedge clk);
    if (armed) begin
      chk("ack", b1.csr_ack_o, e_ack);
      chk("illegal", b1.csr_illegal_o, e_ill);
      chk("rdata", b1.csr_rdata_o, e_rd);
      chk("ack2", b2.csr_ack_o, e2_ack);
      chk("illegal2", b2.csr_illegal_o, e2_ill);
      chk("rdata2", b2.csr_rdata_o, e2_rd);
    end
    rst_n = rn;
    instret = ir;
    b1.csr_req_i = rq;
    b1.csr_op_i = op;
    b1.csr_addr_i = ad;
    b1.csr_wdata_i = wd;
    b2.csr_req_i = s2_req;
    b2.csr_op_i = 2'b00;
    b2.csr_addr_i = s2_addr;
    b2.csr_wdata_i = 8'h00;
    if (!rn) begin
      e_ack = 0; e_ill = 0; e_rd = 0;
      cyc_m = 0; inst_m = 0;
      for (int i = 0; i < DEP; i++) scr_m[i] = 0;
      e2_ack = 0; e2_ill = 0; e2_rd = 0; c2 = 0;
      armed = 1'b1;
    end else begin
      tm = cyc_m / TD;
      hit = 1; v = 0; idx = int'(ad) - 'h7C0;
      case (ad)
        12'hC00: v = cyc_m[31:0];
        12'hC01: v = tm[31:0];
        12'hC02: v = inst_m[31:0];
        12'hC80: v = cyc_m[63:32];
        12'hC81: v = tm[63:32];
        12'hC82: v = inst_m[63:32];
        default: if (idx >= 0 && idx < DEP) v = scr_m[idx]; else hit = 0;
      endcase
      wi = op == 2'b01 || (op[1] && wd != 0);
      ill = !hit || (ad[11:8] == 4'hC && wi);
      e_ack = rq;
      e_ill = rq && ill;
      e_rd = rq && !ill ? v : 0;
      if (rq && !ill && ad[11:8] != 4'hC && wi)
        scr_m[idx] = op == 2'b01 ? wd : op == 2'b10 ? v | wd : v & ~wd;
      cyc_m = cyc_m + 1;
      inst_m = inst_m + 64'(ir);
      hit2 = 1; v2 = 0;
      case (s2_addr)
        12'hC00, 12'hC01: v2 = c2[7:0];
        12'hC80, 12'hC81: v2 = {4'h0, c2[11:8]};
        12'h7C0: v2 = 0;
        default: hit2 = 0;
      endcase
      e2_ack = s2_req;
      e2_ill = s2_req && !hit2;
      e2_rd = s2_req && hit2 ? v2 : 0;
      c2 = c2 + 12'd1;
    end
    s2_req = 1'b0;
  endtask
  task automatic nop();
    step(1, 0, 2'b00, 12'h000, 32'h0, 0);
  endtask
  task automatic rq(input logic [1:0] op, input logic [11:0] ad, input logic [31:0] wd);
    step(1, 1, op, ad, wd, 0);
  endtask
  task automatic rst_cyc();
    step(0, 0, 2'b00, 12'h000, 32'h0, 0);
  endtask
  initial begin
    rst_cyc();
    rst_cyc();
    rq(2'b00, 12'hC00, 0);
    nop();
    chk("t1_c00", b1.csr_rdata_o, 0);
    for (int i = 0; i < DEP; i++) rq(2'b00, 12'(12'h7C0 + i), 0);
    rq(2'b01, 12'h7C0, 32'hF0F0_0000);
    rq(2'b10, 12'h7C0, 32'h0000_00FF);
    chk("t2_rw", b1.csr_rdata_o, 0);
    rq(2'b11, 12'h7C0, 32'hF000_000F);
    chk("t2_rs", b1.csr_rdata_o, 32'hF0F0_0000);
    rq(2'b00, 12'h7C0, 0);
    chk("t2_rc", b1.csr_rdata_o, 32'hF0F0_00FF);
    nop();
    chk("t2_rd", b1.csr_rdata_o, 32'h00F0_00F0);
    rq(2'b01, 12'hC00, 32'h5);
    nop();
    chk("t3_ro_ill", b1.csr_illegal_o, 1);
    chk("t3_ro_rd", b1.csr_rdata_o, 0);
    rq(2'b10, 12'hC00, 0);
    nop();
    chk("t3_rs0_legal", b1.csr_illegal_o, 0);
    rq(2'b00, 12'h7C8, 0);
    nop();
    chk("t3_oob_ill", b1.csr_illegal_o, 1);
    rq(2'b11, 12'hC82, 0);
    rq(2'b00, 12'hC03, 0);
    rq(2'b00, 12'h7BF, 0);
    rst_cyc();
    repeat (12) nop();
    rq(2'b00, 12'hC01, 0);
    nop();
    chk("t4_time", b1.csr_rdata_o, 3);
    repeat (5) step(1, 0, 2'b00, 12'h000, 0, 1);
    rq(2'b00, 12'hC02, 0);
    nop();
    chk("t4_instret", b1.csr_rdata_o, 5);
    rq(2'b00, 12'hC82, 0);
    nop();
    chk("t4_instret_hi", b1.csr_rdata_o, 0);
    rq(2'b01, 12'h7C1, 32'h55);
    step(0, 1, 2'b01, 12'h7C1, 32'h1234, 0);
    nop();
    chk("t6_no_ack", b1.csr_ack_o, 0);
    rq(2'b00, 12'h7C1, 0);
    nop();
    chk("t6_cleared", b1.csr_rdata_o, 0);
    rst_cyc();
    s2_req = 1; s2_addr = 12'h7C1;
    nop();
    nop();
    chk("t5_small_oob", b2.csr_illegal_o, 1);
    while (c2 != 12'h100) nop();
    s2_req = 1; s2_addr = 12'hC00;
    nop();
    s2_req = 1; s2_addr = 12'hC80;
    nop();
    chk("t5_carry_lo", b2.csr_rdata_o, 0);
    nop();
    chk("t5_carry_hi", b2.csr_rdata_o, 1);
    while (c2 != 12'hFFF) nop();
    s2_req = 1; s2_addr = 12'hC80;
    nop();
    s2_req = 1; s2_addr = 12'hC00;
    nop();
    chk("t5_top_hi", b2.csr_rdata_o, 8'h0F);
    s2_req = 1; s2_addr = 12'hC80;
    nop();
    chk("t5_wrap_lo", b2.csr_rdata_o, 0);
    nop();
    chk("t5_wrap_hi", b2.csr_rdata_o, 0);
    nop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
